instruction_sequencer: RTL
==========================

Name: instruction_sequencer

Overview:
Per-core front end that executes programs encoded in the shared 32-bit instruction format. It fetches from the 256-entry code memory, decodes opcode and class, and issues one instruction at a time to the execution units over a valid/ready handshake. Control flow (cjmp, finish, nop) is handled internally. It is the decoding end of the format produced by the program loader and assembler.

Parameters:
CODE_ADDRESS_BITS, 8, code address width; shared package constant, not overridden locally.
FETCH_LATENCY, 1, code memory read latency in cycles; only 1 is supported.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin execution at start_pc; honoured only in IDLE, DONE or ERROR
start_pc  in  8  entry CodeAddress
busy  out  1  high from the cycle after an accepted start until finish or error
done  out  1  high in DONE, cleared by the next start
error  out  1  high in ERROR (illegal opcode), cleared by the next start
pc  out  8  address of the instruction currently held
code_rd  out  1  code memory read strobe
code_addr  out  8  code memory address
code_data  in  32  instruction word, valid FETCH_LATENCY cycles after code_rd
issue_valid  out  1  instruction offered to the execution units
issue_ready  in  1  execution side accepts
issue_instr  out  32  decoded Instruction (opcode + Data)
issue_class  out  2  0 = MultiCycleFPU, 1 = CombFPU, 2 = Async, 3 = Other
exec_done  in  1  completion pulse for MultiCycleFPU and Async classes
cond_flag  in  1  registered result of the last retired compare
retired_count  out  32  instructions retired (optional feature)
stall_cycles  out  32  cycles spent in ISSUE or WAIT (optional feature)

Behaviour:
- Reset: state IDLE, pc = 0; busy, done, error, code_rd, issue_valid = 0; code_addr = 0; issue_instr = 0; issue_class = 0; counters = 0.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT, DONE, ERROR.
- IDLE/DONE/ERROR + start: pc <= start_pc; clear done and error; go to FETCH.
- FETCH (1 cycle): code_rd = 1, code_addr = pc; go to DECODE.
- DECODE: latch code_data into instr.
  - Opcode 0-6 (add to round): class 0.
  - Opcode 7-16 (min to cmp_ne): class 1.
  - Opcode 17-18 (wait_sample, trace): class 2.
  - Opcode 19-23 (copy to cb_load): class 3.
  - All of the above go to ISSUE.
  - cjmp (24): if cond_flag == Data[8], pc <= Data[7:0]; else pc <= pc+1. Go to FETCH; nothing is issued.
  - finish (25): go to DONE.
  - nop (26): pc <= pc+1; go to FETCH.
  - 27-31: go to ERROR; pc holds the offending address.
- ISSUE: issue_valid = 1; issue_instr and issue_class stay stable until the handshake.
  - On issue_valid && issue_ready: class 0 or 2 goes to WAIT; class 1 or 3 retires, pc <= pc+1, go to FETCH.
- WAIT: on exec_done, retire, pc <= pc+1, go to FETCH. exec_done outside WAIT is ignored.
- Minimum cost: 3 cycles per issued instruction, 2 cycles per cjmp or nop.
- pc increments modulo 256 (255 wraps to 0). A cjmp target is used verbatim.
- cond_flag is sampled only in DECODE. The execution side must update it by the cycle after a compare handshake, which is guaranteed because FETCH always sits in between.
- start while busy is ignored. issue_valid must never drop before handshake; the bench checks this.
- rst_n asserted mid-operation returns to IDLE at once and discards any outstanding instruction. exec_done arriving after reset is ignored.

Optional Feature:
SEQ_PERF_COUNTERS_EN.
- Defined: retired_count increments on each issued-instruction retirement and on each cjmp and nop (not finish). stall_cycles increments each cycle in ISSUE with !issue_ready, and each cycle in WAIT. Both counters clear on an accepted start and wrap at 2^32.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package:
  - InstructionOpcode range markers (OP_FirstMultiCycleFPU etc.); class decode uses only these markers, never literal numbers.
  - New InstrClass enum (2 bits).
  - cjmp field constants: CJMP_TARGET_LSB = 0, CJMP_COND_BIT = 8.
  - SEQ_STATE enum.
- Sub-module: instr_class_decode, purely combinational: opcode -> {class, is_cjmp, is_finish, is_nop, illegal}. Reused by the assembler checker.

Test Plan:
- start_pc=0x10; program add, finish; ready=1; exec_done 4 cycles after handshake -> one issue with class 0, instr at 0x10; done rises, busy falls, pc=0x11.
- cmp_lt (class 1) at 0x00, then cjmp at 0x01 with Data[8]=1, target 0x40; cond_flag=1 -> next fetch code_addr=0x40. Repeat with cond_flag=0 -> next fetch at 0x02.
- min at 0x05; issue_ready low for 5 cycles -> issue_valid and issue_instr stable for 6 cycles; stall_cycles=5 (macro on).
- nop at 0xFF -> next fetch at 0x00 (wrap); retired_count=1.
- Opcode 29 at 0x07 -> error=1, busy=0, pc=0x07, no issue_valid; start with start_pc=0 clears error.
- rst_n low during WAIT of trace (17), then exec_done pulse after reset release -> all outputs at reset values, exec_done ignored, state IDLE.

Source files
------------

// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcode ranges, class and state enums, field positions.
package instruction_sequencer_pkg;

    localparam int CODE_ADDRESS_BITS = 8;
    localparam int FETCH_LATENCY     = 1;
    localparam int INSTR_BITS        = 32;
    localparam int OPCODE_BITS       = 5;
    localparam int OPCODE_LSB        = INSTR_BITS - OPCODE_BITS;
    localparam int CJMP_TARGET_LSB   = 0;
    localparam int CJMP_COND_BIT     = 8;

    typedef logic [CODE_ADDRESS_BITS-1:0] code_addr_t;
    typedef logic [OPCODE_BITS-1:0]       opcode_t;

    // Opcode range markers; class decode is expressed only in terms of these.
    localparam opcode_t OP_FirstMultiCycleFPU = 5'd0;
    localparam opcode_t OP_LastMultiCycleFPU  = 5'd6;
    localparam opcode_t OP_FirstCombFPU       = 5'd7;
    localparam opcode_t OP_LastCombFPU        = 5'd16;
    localparam opcode_t OP_FirstAsync         = 5'd17;
    localparam opcode_t OP_LastAsync          = 5'd18;
    localparam opcode_t OP_FirstOther         = 5'd19;
    localparam opcode_t OP_LastOther          = 5'd23;
    localparam opcode_t OP_Cjmp               = 5'd24;
    localparam opcode_t OP_Finish             = 5'd25;
    localparam opcode_t OP_Nop                = 5'd26;

    typedef enum logic [1:0] {
        CLS_MULTI_CYCLE_FPU = 2'd0,
        CLS_COMB_FPU        = 2'd1,
        CLS_ASYNC           = 2'd2,
        CLS_OTHER           = 2'd3
    } instr_class_e;

    typedef enum logic [2:0] {
        SEQ_IDLE, SEQ_FETCH, SEQ_DECODE, SEQ_ISSUE, SEQ_WAIT, SEQ_DONE, SEQ_ERROR
    } seq_state_e;

endpackage

// File: rtl/instruction_sequencer_instr_class_decode.sv
// Combinational opcode classifier: execution class plus control-flow and illegal flags.
module instr_class_decode
    import instruction_sequencer_pkg::*;
(
    input  opcode_t      i_opcode,
    output instr_class_e o_class,
    output logic         o_is_cjmp,
    output logic         o_is_finish,
    output logic         o_is_nop,
    output logic         o_illegal
);

    always_comb begin
        o_class     = CLS_OTHER;
        o_is_cjmp   = 1'b0;
        o_is_finish = 1'b0;
        o_is_nop    = 1'b0;
        o_illegal   = 1'b0;
        // The multi-cycle range starts at opcode zero, so only its upper marker matters.
        if (i_opcode <= OP_LastMultiCycleFPU)
            o_class = CLS_MULTI_CYCLE_FPU;
        else if (i_opcode >= OP_FirstCombFPU && i_opcode <= OP_LastCombFPU)
            o_class = CLS_COMB_FPU;
        else if (i_opcode >= OP_FirstAsync && i_opcode <= OP_LastAsync)
            o_class = CLS_ASYNC;
        else if (i_opcode >= OP_FirstOther && i_opcode <= OP_LastOther)
            o_class = CLS_OTHER;
        else if (i_opcode == OP_Cjmp)
            o_is_cjmp = 1'b1;
        else if (i_opcode == OP_Finish)
            o_is_finish = 1'b1;
        else if (i_opcode == OP_Nop)
            o_is_nop = 1'b1;
        else
            o_illegal = 1'b1;
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Per-core fetch/decode/issue sequencer with internal cjmp/finish/nop handling.
// Optional retire/stall counters are enabled by defining SEQ_PERF_COUNTERS_EN.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  start_pc,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  pc,
    output logic        code_rd,
    output logic [7:0]  code_addr,
    input  logic [31:0] code_data,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [31:0] issue_instr,
    output logic [1:0]  issue_class,
    input  logic        exec_done,
    input  logic        cond_flag,
    output logic [31:0] retired_count,
    output logic [31:0] stall_cycles
);

    seq_state_e   r_state, w_state_next;
    code_addr_t   r_pc, w_pc_next, w_pc_inc, w_cjmp_target;
    logic [31:0]  r_instr;
    instr_class_e r_class, w_dec_class;
    opcode_t      w_opcode;
    logic         w_is_cjmp, w_is_finish, w_is_nop, w_illegal;

    assign w_opcode      = code_data[OPCODE_LSB +: OPCODE_BITS];
    assign w_pc_inc      = r_pc + code_addr_t'(1);
    assign w_cjmp_target = code_data[CJMP_TARGET_LSB +: CODE_ADDRESS_BITS];

    instr_class_decode u_dec (
        .i_opcode    (w_opcode),
        .o_class     (w_dec_class),
        .o_is_cjmp   (w_is_cjmp),
        .o_is_finish (w_is_finish),
        .o_is_nop    (w_is_nop),
        .o_illegal   (w_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= SEQ_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            SEQ_IDLE, SEQ_DONE, SEQ_ERROR: begin
                if (start) begin
                    w_pc_next    = start_pc;
                    w_state_next = SEQ_FETCH;
                end
            end
            SEQ_FETCH: w_state_next = SEQ_DECODE;
            SEQ_DECODE: begin
                if (w_illegal)
                    w_state_next = SEQ_ERROR;
                else if (w_is_finish)
                    w_state_next = SEQ_DONE;
                else if (w_is_cjmp) begin
                    w_pc_next    = (cond_flag == code_data[CJMP_COND_BIT]) ? w_cjmp_target : w_pc_inc;
                    w_state_next = SEQ_FETCH;
                end else if (w_is_nop) begin
                    w_pc_next    = w_pc_inc;
                    w_state_next = SEQ_FETCH;
                end else
                    w_state_next = SEQ_ISSUE;
            end
            SEQ_ISSUE: begin
                if (issue_ready) begin
                    if (r_class == CLS_MULTI_CYCLE_FPU || r_class == CLS_ASYNC)
                        w_state_next = SEQ_WAIT;
                    else begin
                        w_pc_next    = w_pc_inc;
                        w_state_next = SEQ_FETCH;
                    end
                end
            end
            SEQ_WAIT: begin
                if (exec_done) begin
                    w_pc_next    = w_pc_inc;
                    w_state_next = SEQ_FETCH;
                end
            end
            default: w_state_next = SEQ_IDLE;
        endcase
    end

    // The decoded word is captured in DECODE and held steady for the whole issue handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_instr <= '0;
            r_class <= CLS_MULTI_CYCLE_FPU;
        end else begin
            r_pc <= w_pc_next;
            if (r_state == SEQ_DECODE) begin
                r_instr <= code_data;
                r_class <= w_dec_class;
            end
        end
    end

    assign busy        = !(r_state == SEQ_IDLE || r_state == SEQ_DONE || r_state == SEQ_ERROR);
    assign done        = (r_state == SEQ_DONE);
    assign error       = (r_state == SEQ_ERROR);
    assign pc          = r_pc;
    assign code_rd     = (r_state == SEQ_FETCH);
    assign code_addr   = r_pc;
    assign issue_valid = (r_state == SEQ_ISSUE);
    assign issue_instr = r_instr;
    assign issue_class = r_class;

`ifdef SEQ_PERF_COUNTERS_EN
    logic [31:0] r_retired_count, r_stall_cycles;
    logic        w_start_ok, w_retire, w_stall;

    assign w_start_ok = start && !busy;
    // cjmp and nop count as retirements; finish does not.
    assign w_retire = (r_state == SEQ_DECODE && (w_is_cjmp || w_is_nop))
                   || (r_state == SEQ_ISSUE && issue_ready
                       && (r_class == CLS_COMB_FPU || r_class == CLS_OTHER))
                   || (r_state == SEQ_WAIT && exec_done);
    assign w_stall  = (r_state == SEQ_ISSUE && !issue_ready) || (r_state == SEQ_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired_count <= '0;
            r_stall_cycles  <= '0;
        end else if (w_start_ok) begin
            r_retired_count <= '0;
            r_stall_cycles  <= '0;
        end else begin
            if (w_retire) r_retired_count <= r_retired_count + 32'd1;
            if (w_stall)  r_stall_cycles  <= r_stall_cycles + 32'd1;
        end
    end

    assign retired_count = r_retired_count;
    assign stall_cycles  = r_stall_cycles;
`else
    assign retired_count = '0;
    assign stall_cycles  = '0;
`endif

endmodule
